// File: rtl/range_sum_seq.sv
// range_sum_seq: eight 4-bit element bank with a nibble write port and a
// cycle-serial inclusive range-sum engine behind two valid/ready handshakes.
module range_sum_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [3:0]  wr_data,
  output logic [31:0] elems,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_hi,
  input  logic [2:0]  req_lo,
  output logic        sum_valid,
  input  logic        sum_ready,
  output logic [7:0]  sum,
  output logic        busy
);

  localparam int EW = 4;
  localparam int NE = 8;
  localparam int SW = 8;
  localparam int IW = $clog2(NE);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t          state, state_next;
  logic [EW-1:0]   mem [NE];
  logic [IW-1:0]   ptr, end_idx;
  logic [SW-1:0]   acc, sum_q, acc_next;
  logic [IW-1:0]   lo_sel, hi_sel;
  logic            accept, last;

  assign accept   = (state == IDLE) && req_valid;
  assign last     = (ptr == end_idx);
  assign lo_sel   = (req_hi < req_lo) ? req_hi : req_lo;
  assign hi_sel   = (req_hi < req_lo) ? req_lo : req_hi;
  // Each element is zero-extended to the sum width; the read is of the
  // registered element, so a write landing on this edge is not seen here.
  assign acc_next = acc + {{(SW-EW){1'b0}}, mem[ptr]};

  // Element storage: written in any state, cleared by reset.
  // NOTE: the element bank is explicitly reset here because the design
  // must read back zeros after reset; a RAM-style array would not be.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NE; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Pack the registered elements onto the flat bus, element i at [4i+3:4i].
  always_comb begin
    elems = '0;
    for (int i = 0; i < NE; i++) elems[i*EW +: EW] = mem[i];
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (req_valid) state_next = ACC;
      ACC:  if (last)      state_next = DONE;
      DONE: if (sum_ready) state_next = IDLE;
      default:             state_next = IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    req_ready = 1'b0;
    sum_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE:    req_ready = 1'b1;
      ACC:     busy      = 1'b1;
      DONE:    begin sum_valid = 1'b1; busy = 1'b1; end
      default: req_ready = 1'b0;
    endcase
  end

  // Datapath: latch ordered bounds on accept, walk ptr up to end_idx,
  // and capture the final sum on the last accumulation edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      end_idx <= '0;
      acc     <= '0;
      sum_q   <= '0;
    end else if (accept) begin
      ptr     <= lo_sel;
      end_idx <= hi_sel;
      acc     <= '0;
    end else if (state == ACC) begin
      acc <= acc_next;
      if (last) sum_q <= acc_next;
      else      ptr   <= ptr + 1'b1;
    end
  end

  assign sum = sum_q;

endmodule
